// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register: captures decoded ID fields and presents them to EX one cycle later.
// Supports stall (freeze), squash (flush) and bubble insertion via valid_in.
module id_ex_pipe_reg #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned REG_ADDR_W = 4,
  parameter int unsigned EXE_CMD_W  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  freeze,
  input  logic                  valid_in,
  input  logic [DATA_W-1:0]     pc_in,
  input  logic                  wb_en_in,
  input  logic                  mem_r_en_in,
  input  logic                  mem_w_en_in,
  input  logic                  b_in,
  input  logic                  s_in,
  input  logic [EXE_CMD_W-1:0]  exe_cmd_in,
  input  logic [DATA_W-1:0]     val_rn_in,
  input  logic [DATA_W-1:0]     val_rm_in,
  input  logic                  imm_in,
  input  logic [11:0]           shift_operand_in,
  input  logic [23:0]           signed_imm_24_in,
  input  logic [REG_ADDR_W-1:0] dest_in,
  input  logic [REG_ADDR_W-1:0] src1_in,
  input  logic [REG_ADDR_W-1:0] src2_in,
  input  logic [3:0]            status_in,
  output logic [DATA_W-1:0]     pc_out,
  output logic                  wb_en_out,
  output logic                  mem_r_en_out,
  output logic                  mem_w_en_out,
  output logic                  b_out,
  output logic                  s_out,
  output logic [EXE_CMD_W-1:0]  exe_cmd_out,
  output logic [DATA_W-1:0]     val_rn_out,
  output logic [DATA_W-1:0]     val_rm_out,
  output logic                  imm_out,
  output logic [11:0]           shift_operand_out,
  output logic [23:0]           signed_imm_24_out,
  output logic [REG_ADDR_W-1:0] dest_out,
  output logic [REG_ADDR_W-1:0] src1_out,
  output logic [REG_ADDR_W-1:0] src2_out,
  output logic [3:0]            status_out,
  output logic                  mem_type_out,
  output logic                  valid_out
);

  typedef struct packed {
    logic [DATA_W-1:0]     pc;
    logic                  wb_en;
    logic                  mem_r_en;
    logic                  mem_w_en;
    logic                  b;
    logic                  s;
    logic [EXE_CMD_W-1:0]  exe_cmd;
    logic [DATA_W-1:0]     val_rn;
    logic [DATA_W-1:0]     val_rm;
    logic                  imm;
    logic [11:0]           shift_operand;
    logic [23:0]           signed_imm_24;
    logic [REG_ADDR_W-1:0] dest;
    logic [REG_ADDR_W-1:0] src1;
    logic [REG_ADDR_W-1:0] src2;
    logic [3:0]            status;
    logic                  mem_type;
    logic                  valid;
  } entry_t;

  entry_t r_entry;
  entry_t w_load;

  // Build the entry to load; a bubble keeps data fields but clears every side-effect control.
  always_comb begin
    w_load               = '0;
    w_load.pc            = pc_in;
    w_load.exe_cmd       = exe_cmd_in;
    w_load.val_rn        = val_rn_in;
    w_load.val_rm        = val_rm_in;
    w_load.imm           = imm_in;
    w_load.shift_operand = shift_operand_in;
    w_load.signed_imm_24 = signed_imm_24_in;
    w_load.dest          = dest_in;
    w_load.src1          = src1_in;
    w_load.src2          = src2_in;
    w_load.status        = status_in;
    if (valid_in) begin
      w_load.wb_en    = wb_en_in;
      w_load.mem_r_en = mem_r_en_in;
      w_load.mem_w_en = mem_w_en_in;
      w_load.b        = b_in;
      w_load.s        = s_in;
      // Illegal load+store from ID still marks a memory access for the shifter.
      w_load.mem_type = mem_r_en_in | mem_w_en_in;
      w_load.valid    = 1'b1;
    end
  end

  // Entry register: reset beats flush beats freeze beats load.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_entry <= '0;
    end else if (flush) begin
      r_entry <= '0;
    end else if (!freeze) begin
      r_entry <= w_load;
    end
  end

  assign pc_out            = r_entry.pc;
  assign wb_en_out         = r_entry.wb_en;
  assign mem_r_en_out      = r_entry.mem_r_en;
  assign mem_w_en_out      = r_entry.mem_w_en;
  assign b_out             = r_entry.b;
  assign s_out             = r_entry.s;
  assign exe_cmd_out       = r_entry.exe_cmd;
  assign val_rn_out        = r_entry.val_rn;
  assign val_rm_out        = r_entry.val_rm;
  assign imm_out           = r_entry.imm;
  assign shift_operand_out = r_entry.shift_operand;
  assign signed_imm_24_out = r_entry.signed_imm_24;
  assign dest_out          = r_entry.dest;
  assign src1_out          = r_entry.src1;
  assign src2_out          = r_entry.src2;
  assign status_out        = r_entry.status;
  assign mem_type_out      = r_entry.mem_type;
  assign valid_out         = r_entry.valid;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Directed bench for the ID/EX pipeline register.
module tb_id_ex_pipe_reg;

  logic        clk = 1'b0;
  logic        rst, flush, freeze, valid_in;
  logic [31:0] pc_in, val_rn_in, val_rm_in;
  logic        wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in, imm_in;
  logic [3:0]  exe_cmd_in, dest_in, src1_in, src2_in, status_in;
  logic [11:0] shift_operand_in;
  logic [23:0] signed_imm_24_in;

  logic [31:0] pc_out, val_rn_out, val_rm_out;
  logic        wb_en_out, mem_r_en_out, mem_w_en_out, b_out, s_out, imm_out;
  logic [3:0]  exe_cmd_out, dest_out, src1_out, src2_out, status_out;
  logic [11:0] shift_operand_out;
  logic [23:0] signed_imm_24_out;
  logic        mem_type_out, valid_out;

  int total = 0;
  int bad   = 0;

  id_ex_pipe_reg dut (
    .clk(clk), .rst(rst), .flush(flush), .freeze(freeze), .valid_in(valid_in),
    .pc_in(pc_in), .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in),
    .mem_w_en_in(mem_w_en_in), .b_in(b_in), .s_in(s_in), .exe_cmd_in(exe_cmd_in),
    .val_rn_in(val_rn_in), .val_rm_in(val_rm_in), .imm_in(imm_in),
    .shift_operand_in(shift_operand_in), .signed_imm_24_in(signed_imm_24_in),
    .dest_in(dest_in), .src1_in(src1_in), .src2_in(src2_in), .status_in(status_in),
    .pc_out(pc_out), .wb_en_out(wb_en_out), .mem_r_en_out(mem_r_en_out),
    .mem_w_en_out(mem_w_en_out), .b_out(b_out), .s_out(s_out), .exe_cmd_out(exe_cmd_out),
    .val_rn_out(val_rn_out), .val_rm_out(val_rm_out), .imm_out(imm_out),
    .shift_operand_out(shift_operand_out), .signed_imm_24_out(signed_imm_24_out),
    .dest_out(dest_out), .src1_out(src1_out), .src2_out(src2_out), .status_out(status_out),
    .mem_type_out(mem_type_out), .valid_out(valid_out)
  );

  always #5 clk = ~clk;

  function automatic logic any_out();
    return (|pc_out) | wb_en_out | mem_r_en_out | mem_w_en_out | b_out | s_out |
           (|exe_cmd_out) | (|val_rn_out) | (|val_rm_out) | imm_out | (|shift_operand_out) |
           (|signed_imm_24_out) | (|dest_out) | (|src1_out) | (|src2_out) | (|status_out) |
           mem_type_out | valid_out;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs are driven and outputs sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    flush = 0; freeze = 0; valid_in = 0;
    pc_in = 0; wb_en_in = 0; mem_r_en_in = 0; mem_w_en_in = 0; b_in = 0; s_in = 0;
    exe_cmd_in = 0; val_rn_in = 0; val_rm_in = 0; imm_in = 0; shift_operand_in = 0;
    signed_imm_24_in = 0; dest_in = 0; src1_in = 0; src2_in = 0; status_in = 0;
  endtask

  logic [31:0] ror_res;

  initial begin
    rst = 1;
    clear_inputs();
    // 1. Reset with a valid ADD waiting, then release.
    valid_in = 1; pc_in = 32'h8; exe_cmd_in = 4'b0010; wb_en_in = 1; status_in = 4'hF;
    src1_in = 4'd1; src2_in = 4'd2; dest_in = 4'd3;
    step();
    chk("rst_c1_any", {63'b0, any_out()}, 64'd0);
    step();
    chk("rst_c2_any", {63'b0, any_out()}, 64'd0);
    chk("rst_c2_status", {60'b0, status_out}, 64'd0);
    rst = 0;
    step();
    chk("add_pc", {32'b0, pc_out}, 64'h8);
    chk("add_cmd", {60'b0, exe_cmd_out}, 64'h2);
    chk("add_wb", {63'b0, wb_en_out}, 64'd1);
    chk("add_valid", {63'b0, valid_out}, 64'd1);
    chk("add_regs", {52'b0, dest_out, src1_out, src2_out}, 64'h312);
    chk("add_status", {60'b0, status_out}, 64'hF);

    // 2. Operand for ROR #1.
    clear_inputs();
    valid_in = 1; pc_in = 32'hC; val_rm_in = 32'h8000_0001; shift_operand_in = 12'h0E0;
    val_rn_in = 32'h1234_5678; signed_imm_24_in = 24'hABCDEF;
    step();
    chk("ror_rm", {32'b0, val_rm_out}, 64'h8000_0001);
    chk("ror_shop", {52'b0, shift_operand_out}, 64'h0E0);
    chk("ror_imm", {63'b0, imm_out}, 64'd0);
    chk("ror_rn", {32'b0, val_rn_out}, 64'h1234_5678);
    chk("ror_imm24", {40'b0, signed_imm_24_out}, 64'hABCDEF);
    ror_res = {val_rm_out[0], val_rm_out[31:1]};
    chk("ror_result", {32'b0, ror_res}, 64'hC000_0000);

    // 3. Freeze for 3 cycles with changing inputs.
    for (int i = 0; i < 3; i++) begin
      freeze = 1; pc_in = 32'h100 + i; val_rm_in = i; wb_en_in = 1; dest_in = 4'(i + 7);
      step();
      chk("frz_pc", {32'b0, pc_out}, 64'hC);
      chk("frz_rm", {32'b0, val_rm_out}, 64'h8000_0001);
      chk("frz_wb", {63'b0, wb_en_out}, 64'd0);
    end
    freeze = 0; pc_in = 32'h200; val_rm_in = 32'h55; dest_in = 4'd9;
    step();
    chk("unfrz_pc", {32'b0, pc_out}, 64'h200);
    chk("unfrz_rm", {32'b0, val_rm_out}, 64'h55);
    chk("unfrz_dest", {60'b0, dest_out}, 64'd9);

    // 4. Valid STR, then flush and freeze together.
    clear_inputs();
    valid_in = 1; pc_in = 32'h20; mem_w_en_in = 1; exe_cmd_in = 4'b0010; dest_in = 4'd4;
    step();
    chk("str_mw", {63'b0, mem_w_en_out}, 64'd1);
    chk("str_mtype", {63'b0, mem_type_out}, 64'd1);
    flush = 1; freeze = 1;
    step();
    chk("flush_any", {63'b0, any_out()}, 64'd0);
    chk("flush_valid", {63'b0, valid_out}, 64'd0);

    // 5. Bubble with live control bits.
    clear_inputs();
    valid_in = 0; wb_en_in = 1; mem_w_en_in = 1; b_in = 1; s_in = 1; dest_in = 4'd5;
    pc_in = 32'h24;
    step();
    chk("bub_ctrl", {58'b0, wb_en_out, mem_w_en_out, b_out, s_out, valid_out, mem_type_out},
        64'd0);
    chk("bub_dest", {60'b0, dest_out}, 64'd5);

    // 6. LDR then MOV immediate.
    clear_inputs();
    valid_in = 1; mem_r_en_in = 1; wb_en_in = 1; imm_in = 0;
    step();
    chk("ldr_mtype", {63'b0, mem_type_out}, 64'd1);
    chk("ldr_mr", {63'b0, mem_r_en_out}, 64'd1);
    mem_r_en_in = 0; imm_in = 1; exe_cmd_in = 4'b0001;
    step();
    chk("mov_mtype", {63'b0, mem_type_out}, 64'd0);
    chk("mov_imm", {63'b0, imm_out}, 64'd1);

    // Illegal load+store pair registers as given.
    mem_r_en_in = 1; mem_w_en_in = 1;
    step();
    chk("both_mem", {61'b0, mem_r_en_out, mem_w_en_out, mem_type_out}, 64'h7);

    // Reset during a stall clears everything.
    freeze = 1; rst = 1;
    step();
    chk("rst_frz_any", {63'b0, any_out()}, 64'd0);
    rst = 0; freeze = 0;
    step();
    chk("post_rst_valid", {63'b0, valid_out}, 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
